// File: rtl/div_unit.sv
// Iterative signed divider, radix-2 non-restoring, one add/sub per cycle.
// Quotient goes to LO, remainder to HI; done pulses once per accepted start.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_nx;

    logic [W:0]    acc;
    logic [W:0]    m_reg;
    logic [W-1:0]  q_reg;
    logic [CW-1:0] cnt;
    logic          sq;
    logic          sr;

    logic          accept;
    logic          dz;
    logic [W-1:0]  nd_mag;
    logic [W-1:0]  dv_mag;
    logic [W:0]    a_sh;
    logic [W:0]    step;
    logic [W-1:0]  a_fix;

    assign accept = start && (state == IDLE || state == DONE);
    assign dz     = (divisor == '0);
    assign nd_mag = dividend[W-1] ? -dividend : dividend;
    assign dv_mag = divisor[W-1]  ? -divisor  : divisor;

    // Sign test uses A before the shift; wraparound in the shifted value
    // cancels once M is added or subtracted.
    assign a_sh  = {acc[W-1:0], q_reg[W-1]};
    assign step  = acc[W] ? a_sh + m_reg : a_sh - m_reg;
    assign a_fix = acc[W] ? acc[W-1:0] + m_reg[W-1:0] : acc[W-1:0];

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = dz ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nx = dz ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            acc         <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            acc         <= '0;
            m_reg       <= {1'b0, dv_mag};
            q_reg       <= nd_mag;
            cnt         <= '0;
            sq          <= dividend[W-1] ^ divisor[W-1];
            sr          <= dividend[W-1];
            div_by_zero <= dz;
            if (dz) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            acc   <= step;
            q_reg <= {q_reg[W-2:0], ~step[W]};
            cnt   <= cnt + 1'b1;
        end else if (state == FIX) begin
            quotient  <= sq ? -q_reg : q_reg;
            remainder <= sr ? -a_fix : a_fix;
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit signed integer divider for the datapath's DIV instruction. It sits alongside the 32-bit carry-lookahead adder as a multi-cycle ALU stage. It produces the quotient (written to LO) and the remainder (written to HI) using radix-2 non-restoring division, one add/subtract per cycle. The control unit starts it with a one-cycle pulse and waits for `done` before loading HI/LO.

## Interface
- `DATA_WIDTH`, 32, operand/result width; iteration count equals `DATA_WIDTH`.

- `clock`  in  1  rising-edge clock
- `clear`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; honoured only in IDLE or DONE
- `dividend`  in  DATA_WIDTH  signed two's-complement numerator, sampled on the accepting edge
- `divisor`  in  DATA_WIDTH  signed two's-complement denominator, sampled on the accepting edge
- `quotient`  out  DATA_WIDTH  signed quotient (LO)
- `remainder`  out  DATA_WIDTH  signed remainder (HI)
- `busy`  out  1  high while a division is in progress
- `done`  out  1  one-cycle pulse; results valid from this cycle
- `div_by_zero`  out  1  high with `done` when the divisor was 0; held until next accept

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + `start` captures the operands and records:
  - `sq = dividend[MSB] ^ divisor[MSB]` (quotient sign);
  - `sr = dividend[MSB]` (remainder sign);
  - the unsigned magnitudes of both operands.
- After capture:
  - divisor ≠ 0: go to RUN with iteration counter = 0.
  - divisor = 0: go to DONE.
- RUN, non-restoring step, once per cycle:
  - Registers: partial remainder A is DATA_WIDTH+1 bits; Q holds the dividend magnitude; M holds the divisor magnitude.
  - Shift {A,Q} left 1.
  - If A was negative before the shift, A = A + M; otherwise A = A − M.
  - Q[0] = ~A[MSB] (the new A).
  - The counter increments. After DATA_WIDTH steps, go to FIX.
- FIX (1 cycle):
  - If A is negative, A = A + M.
  - Then `quotient` = sq ? −Q : Q and `remainder` = sr ? −A[DATA_WIDTH-1:0] : A[DATA_WIDTH-1:0].
  - Go to DONE.
- DONE (1 cycle): `done` = 1, then go to IDLE unless `start` is accepted in the same cycle.
- Arithmetic rules:
  - Truncation is toward zero, and the remainder takes the dividend's sign.
  - Negation is two's complement modulo 2^DATA_WIDTH. Therefore 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no overflow flag.
- Divide by zero: `quotient` = all ones, `remainder` = dividend (unchanged), `div_by_zero` = 1.
- `start` while in RUN or FIX is ignored. Operand changes after capture have no effect.
- `quotient`, `remainder` and `div_by_zero` hold their values from DONE until the next accepting edge. At the accepting edge `div_by_zero` clears, or sets for a new zero divisor.

## Timing
- `clear` forces IDLE on the next edge, including mid-RUN or mid-FIX. The operation in progress is discarded with no `done`.
- Output values while `clear` is asserted and after reset: `quotient` = 0, `remainder` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0.
- `clear` has priority over `start` on the same edge.
- Let edge 0 be the edge that accepts `start`:
  - `busy` is high from edge 0 through the cycle before `done`, i.e. DATA_WIDTH+1 = 33 cycles (RUN ×32, FIX ×1).
  - `done` is high in the cycle following edge 33, so the latency is 34 cycles, start to done.
  - `busy` is low in the `done` cycle.
- Divide by zero: `busy` stays low and `done` is high in the cycle following edge 0 (latency 1).
- Back-to-back: `start` asserted during the `done` cycle is accepted on the edge ending that cycle, giving a 34-cycle issue interval.
- `busy` and `done` are never high simultaneously. `done` is never high for two consecutive cycles unless a divide-by-zero is accepted during DONE.

## Test plan
- 100 / 7:
  - `done` in the 34th cycle after the accept;
  - quotient 14 (0x0000000E), remainder 2;
  - `busy` high for exactly 33 cycles.
- −100 / 7 → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2). 100 / −7 → quotient −14, remainder 2.
- 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. 0x7FFFFFFF / 1 → quotient 0x7FFFFFFF, remainder 0. 5 / 9 → quotient 0, remainder 5.
- 1234 / 0:
  - `done` in the cycle after the accept, `div_by_zero` = 1, quotient 0xFFFFFFFF, remainder 1234.
  - A following 10 / 3 then clears `div_by_zero` and returns quotient 3, remainder 1.
- Start 100 / 7, then at RUN cycle 10:
  - Pulse `start` with 9 / 3 and change the operand inputs; both are ignored and the result is still quotient 14, remainder 2.
  - Repeat the run and assert `clear` at RUN cycle 20: all outputs are 0 and no `done` pulse appears.
- Back-to-back: `start` 50 / 5 asserted again in the `done` cycle of 100 / 7 → second `done` 34 cycles later with quotient 10, remainder 0.
